// File: rtl/hazard_scoreboard_mu.sv
// Decode-stage register scoreboard tracking pending writes from multi-cycle units.
// Detects RAW/WAW/structural hazards, releases on completion, adds a stall watchdog.
//
// Ports:
//   CLK, rst           clock (rising edge), synchronous active-high reset
//   issue_*            decode-stage instruction: valid, long, unit, rs1/rs2 (+use), rd (+wr)
//   flush              kills the current decode instruction
//   done_valid         per-unit one-cycle completion pulse
//   stall, nop_ins     hold PC/IF-ID and insert a bubble into ID/EX
//   issue_acc          instruction accepted this cycle
//   pending, unit_busy per-register pending-write mask, per-unit occupied mask
//   wdog, sb_err       stall-timeout flag, sticky done-on-idle-unit flag
module hazard_scoreboard_mu #(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_UNITS = 4,
  parameter int UNIT_IDW  = 2,
  parameter int X0_ZERO   = 1,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_long,
  input  logic [UNIT_IDW-1:0]  issue_unit,
  input  logic [REG_AW-1:0]    issue_rs1,
  input  logic [REG_AW-1:0]    issue_rs2,
  input  logic                 issue_use_rs1,
  input  logic                 issue_use_rs2,
  input  logic [REG_AW-1:0]    issue_rd,
  input  logic                 issue_wr_rd,
  input  logic                 flush,
  input  logic [NUM_UNITS-1:0] done_valid,
  output logic                 stall,
  output logic                 nop_ins,
  output logic                 issue_acc,
  output logic [NUM_REGS-1:0]  pending,
  output logic [NUM_UNITS-1:0] unit_busy,
  output logic                 wdog,
  output logic                 sb_err
);

  localparam logic LP_X0 = (X0_ZERO != 0);

  logic [NUM_REGS-1:0]  r_pend;
  logic [UNIT_IDW-1:0]  r_owner [NUM_REGS];
  logic [NUM_UNITS-1:0] r_busy;
  logic [REG_AW-1:0]    r_urd [NUM_UNITS];
  logic [NUM_UNITS-1:0] r_uwr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_wdog;
  logic                 r_err;

  logic [NUM_UNITS-1:0] w_rel;
  logic [NUM_REGS-1:0]  w_eff;
  logic                 w_raw;
  logic                 w_waw;
  logic                 w_strc;
  logic                 w_go;
  logic                 w_stall;
  logic                 w_acc;
  logic                 w_rec;
  logic                 w_set;
  logic [NUM_REGS-1:0]  w_pend_nxt;
  logic [NUM_UNITS-1:0] w_busy_nxt;

  assign w_rel = done_valid & r_busy;

  // A pending bit is already gone this cycle if its owning unit is
  // completing and that unit's recorded destination is this register.
  always_comb begin
    w_eff = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_eff[r] = r_pend[r] &
        ~(w_rel[r_owner[r]] & r_uwr[r_owner[r]] &
          (r_urd[r_owner[r]] == REG_AW'(r)));
    end
    if (LP_X0) w_eff[0] = 1'b0;
  end

  assign w_raw = (issue_use_rs1 & w_eff[issue_rs1]) |
                 (issue_use_rs2 & w_eff[issue_rs2]);
  assign w_waw = issue_wr_rd & w_eff[issue_rd];
  assign w_strc = issue_long & r_busy[issue_unit] &
                  ~w_rel[issue_unit];

  assign w_go    = issue_valid & ~flush;
  assign w_stall = w_go & (w_raw | w_waw | w_strc);
  assign w_acc   = w_go & ~w_stall;

  assign w_rec = issue_wr_rd & ~(LP_X0 && (issue_rd == '0));
  assign w_set = w_acc & issue_long;

  // Clears first, then a same-cycle accepted issue sets on top.
  always_comb begin
    w_pend_nxt = w_eff;
    w_busy_nxt = r_busy & ~w_rel;
    if (w_set) begin
      w_busy_nxt[issue_unit] = 1'b1;
      if (w_rec) w_pend_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_pend <= '0;
      r_busy <= '0;
      r_uwr  <= '0;
      r_cnt  <= '0;
      r_wdog <= 1'b0;
      r_err  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) r_owner[r] <= '0;
      for (int u = 0; u < NUM_UNITS; u++) r_urd[u] <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_busy <= w_busy_nxt;
      r_err  <= r_err | (|(done_valid & ~r_busy));
      r_wdog <= (r_cnt >= CNT_W'(TIMEOUT));
      if (w_stall) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_set) begin
        r_urd[issue_unit] <= issue_rd;
        r_uwr[issue_unit] <= w_rec;
        if (w_rec) r_owner[issue_rd] <= issue_unit;
      end
    end
  end

  assign stall     = w_stall;
  assign nop_ins   = w_stall;
  assign issue_acc = w_acc;
  assign pending   = r_pend;
  assign unit_busy = r_busy;
  assign wdog      = r_wdog;
  assign sb_err    = r_err;

endmodule

// File: tb/tb_hazard_scoreboard_mu.sv
// Scoreboard bench for hazard_scoreboard_mu: directed cycles push expected
// outputs into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard_mu;

  logic        CLK = 1'b0;
  logic        rst;
  logic        issue_valid, issue_long;
  logic [1:0]  issue_unit;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs1, issue_use_rs2, issue_wr_rd;
  logic        flush;
  logic [3:0]  done_valid;
  logic        stall, nop_ins, issue_acc;
  logic [31:0] pending;
  logic [3:0]  unit_busy;
  logic        wdog, sb_err;

  hazard_scoreboard_mu dut (
    .CLK(CLK), .rst(rst),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_unit(issue_unit),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_wr_rd(issue_wr_rd),
    .flush(flush), .done_valid(done_valid),
    .stall(stall), .nop_ins(nop_ins), .issue_acc(issue_acc),
    .pending(pending), .unit_busy(unit_busy),
    .wdog(wdog), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic        st, acc;
    logic [31:0] pm, pe;
    logic [3:0]  bm, be;
    logic        wm, we, sm, se;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int sid = 0;

  logic [31:0] g_pm, g_pe;
  logic [3:0]  g_bm, g_be;
  logic        g_wm, g_we, g_sm, g_se;

  task automatic clr_g();
    g_pm = '0; g_pe = '0; g_bm = '0; g_be = '0;
    g_wm = 0; g_we = 0; g_sm = 0; g_se = 0;
  endtask

  task automatic exp_p(input logic [31:0] v);
    g_pm = '1; g_pe = v;
  endtask
  task automatic exp_b(input logic [3:0] v);
    g_bm = '1; g_be = v;
  endtask
  task automatic exp_w(input logic v);
    g_wm = 1; g_we = v;
  endtask
  task automatic exp_s(input logic v);
    g_sm = 1; g_se = v;
  endtask

  // One cycle: drive inputs after the edge, queue the expected response.
  task automatic step(
    input logic r, v, lng, input logic [1:0] u,
    input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd, input logic wr,
    input logic fl, input logic [3:0] dn,
    input logic es, ea);
    exp_t e;
    @(posedge CLK); #1;
    rst = r; issue_valid = v; issue_long = lng;
    issue_unit = u; issue_rs1 = rs1; issue_use_rs1 = u1;
    issue_rs2 = rs2; issue_use_rs2 = u2;
    issue_rd = rd; issue_wr_rd = wr;
    flush = fl; done_valid = dn;
    sid++;
    e.id = sid; e.st = es; e.acc = ea;
    e.pm = g_pm; e.pe = g_pe; e.bm = g_bm; e.be = g_be;
    e.wm = g_wm; e.we = g_we; e.sm = g_sm; e.se = g_se;
    q.push_back(e);
    clr_g();
  endtask

  task automatic idle(input logic [3:0] dn);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dn, 0, 0);
  endtask

  // Monitor: one queued cycle compared per negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (stall !== e.st) begin
          errors++;
          $display("FAIL stall s%0d got %b want %b", e.id, stall, e.st);
        end
        checks++;
        if (nop_ins !== e.st) begin
          errors++;
          $display("FAIL nop s%0d got %b want %b", e.id, nop_ins, e.st);
        end
        checks++;
        if (issue_acc !== e.acc) begin
          errors++;
          $display("FAIL acc s%0d got %b want %b", e.id, issue_acc, e.acc);
        end
        if (e.pm != 0) begin
          checks++;
          if (((pending ^ e.pe) & e.pm) != 0) begin
            errors++;
            $display("FAIL pend s%0d got %h want %h", e.id, pending, e.pe);
          end
        end
        if (e.bm != 0) begin
          checks++;
          if (((unit_busy ^ e.be) & e.bm) != 0) begin
            errors++;
            $display("FAIL busy s%0d got %b want %b", e.id, unit_busy, e.be);
          end
        end
        if (e.wm) begin
          checks++;
          if (wdog !== e.we) begin
            errors++;
            $display("FAIL wdog s%0d got %b want %b", e.id, wdog, e.we);
          end
        end
        if (e.sm) begin
          checks++;
          if (sb_err !== e.se) begin
            errors++;
            $display("FAIL sberr s%0d got %b want %b", e.id, sb_err, e.se);
          end
        end
      end
    end
  end

  initial begin
    rst = 1; issue_valid = 0; issue_long = 0; issue_unit = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
    issue_rd = 0; issue_wr_rd = 0; flush = 0; done_valid = 0;
    clr_g();

    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_p(0); exp_b(0); exp_w(0); exp_s(0);
    idle(0);

    // RAW on divide result, released on done cycle
    step(0, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    exp_p(32'h20); exp_b(4'b0001);
    step(0, 1, 0, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0);
    exp_p(32'h20);
    step(0, 1, 0, 0, 5, 1, 0, 0, 6, 1, 0, 4'b0001, 0, 1);
    exp_p(0); exp_b(0);
    idle(0);

    // x0 destination never tracked
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    exp_p(0); exp_b(4'b0010);
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    exp_b(4'b0010);
    idle(4'b0010);
    exp_b(0);
    idle(0);

    // structural hazard, freed on same-cycle completion
    step(0, 1, 1, 2, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1);
    exp_p(32'h200); exp_b(4'b0100);
    step(0, 1, 1, 2, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0, 10, 1, 0, 4'b0100, 0, 1);
    exp_p(32'h400); exp_b(4'b0100);
    idle(0);
    idle(4'b0100);
    exp_p(0); exp_b(0); exp_s(0);
    idle(0);

    // WAW on rd7, ownership moves to unit3
    step(0, 1, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
    exp_p(32'h80); exp_b(4'b0001);
    step(0, 1, 1, 3, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0);
    step(0, 1, 1, 3, 0, 0, 0, 0, 7, 1, 0, 4'b0001, 0, 1);
    exp_p(32'h80); exp_b(4'b1000);
    idle(0);
    idle(4'b1000);
    exp_p(0); exp_b(0);
    idle(0);

    // flush beats stall and records nothing; then watchdog
    step(0, 1, 1, 0, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1);
    exp_p(32'h1000); exp_b(4'b0001);
    step(0, 1, 1, 1, 0, 0, 12, 1, 13, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 203; k++) begin
      if (k == 1) begin
        exp_p(32'h1000); exp_b(4'b0001);
      end
      if (k <= 200) exp_w(0);
      if (k == 203) exp_w(1);
      step(0, 1, 0, 0, 0, 0, 12, 1, 14, 1, 0, 0, 1, 0);
    end
    exp_w(1);
    step(0, 1, 0, 0, 0, 0, 12, 1, 14, 1, 0, 4'b0001, 0, 1);
    exp_p(0); exp_b(0);
    idle(0);
    exp_w(0);
    idle(0);

    // sticky error, then reset mid-divide
    exp_s(0);
    idle(4'b0010);
    exp_s(1);
    idle(0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 1);
    exp_s(1); exp_p(32'h100000); exp_b(4'b0001);
    idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_p(0); exp_b(0); exp_w(0); exp_s(0);
    step(0, 1, 0, 0, 20, 1, 0, 0, 21, 1, 0, 0, 0, 1);
    exp_s(0); exp_p(0);
    idle(0);

    @(posedge CLK); #1;
    issue_valid = 0; done_valid = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
